// File: rtl/gf_inverse_seq.sv
// gf_inverse_seq: sequential GF(2^M) inverter, out = in^(2^M-2), standard basis.
// Define GF_INV_VERIFY_EN to add a CHECK state that confirms in*out == 1.
`ifndef MAX_M
`define MAX_M 16
`endif

module gf_inverse_seq #(
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [M-1:0] in,
  output logic         ready,
  output logic         done,
  output logic [M-1:0] out,
  output logic         zero_err,
  output logic         check_fail
);

  // Primitive polynomials shared with the BCH codec, full form including x^M.
  function automatic logic [16:0] prim_poly(input int m);
    case (m)
      2:       prim_poly = 17'h00007;
      3:       prim_poly = 17'h0000B;
      4:       prim_poly = 17'h00013;
      5:       prim_poly = 17'h00025;
      6:       prim_poly = 17'h00043;
      7:       prim_poly = 17'h00089;
      8:       prim_poly = 17'h0011D;
      9:       prim_poly = 17'h00211;
      10:      prim_poly = 17'h00409;
      11:      prim_poly = 17'h00805;
      12:      prim_poly = 17'h01053;
      13:      prim_poly = 17'h0201B;
      14:      prim_poly = 17'h04443;
      15:      prim_poly = 17'h08003;
      default: prim_poly = 17'h1100B;
    endcase
  endfunction

  localparam logic [M-1:0] POLY = M'(prim_poly(M));
  localparam int           CW   = (M > 2) ? $clog2(M) : 1;

  // Fold bits x^i (i >= M) back using x^M = POLY, top bit first.
  function automatic logic [M-1:0] gf_reduce(input logic [2*M-2:0] p);
    logic [2*M-2:0] r;
    r = p;
    for (int i = 2*M-2; i >= M; i--) begin
      if (r[i]) r[i-M +: M] = r[i-M +: M] ^ POLY;
    end
    return r[M-1:0];
  endfunction

  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y);
    logic [2*M-2:0] p;
    p = '0;
    for (int j = 0; j < M; j++) begin
      if (y[j]) p = p ^ ((2*M-1)'(x) << j);
    end
    return gf_reduce(p);
  endfunction

  // Squaring in characteristic 2 just spreads the bits apart before reduction.
  function automatic logic [M-1:0] gf_sq(input logic [M-1:0] x);
    logic [2*M-2:0] p;
    p = '0;
    for (int j = 0; j < M; j++) p[2*j] = x[j];
    return gf_reduce(p);
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, CHECK} state_t;

  state_t        state;
  logic [M-1:0]  sq;
  logic [M-1:0]  acc;
  logic [CW-1:0] cnt;
  logic [M-1:0]  sq2;
  logic [M-1:0]  mul_x;
  logic [M-1:0]  mul_y;
  logic [M-1:0]  prod;

`ifdef GF_INV_VERIFY_EN
  logic [M-1:0]  a;
`endif

  // The single multiplier serves acc*sq^2 in RUN and a*acc in CHECK.
  always_comb begin
    sq2   = gf_sq(sq);
    mul_x = acc;
    mul_y = sq2;
`ifdef GF_INV_VERIFY_EN
    if (state == CHECK) begin
      mul_x = a;
      mul_y = acc;
    end
`endif
    prod = gf_mul(mul_x, mul_y);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ready      <= 1'b1;
      done       <= 1'b0;
      out        <= '0;
      zero_err   <= 1'b0;
      check_fail <= 1'b0;
      sq         <= '0;
      acc        <= '0;
      cnt        <= '0;
`ifdef GF_INV_VERIFY_EN
      a          <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && ready) begin
`ifdef GF_INV_VERIFY_EN
            a        <= in;
`endif
            sq       <= in;
            acc      <= M'(1);
            cnt      <= CW'(M-2);
            ready    <= 1'b0;
            zero_err <= (in == '0);
            state    <= RUN;
          end
        end
        RUN: begin
          sq  <= sq2;
          acc <= prod;
          if (cnt == '0) begin
`ifdef GF_INV_VERIFY_EN
            state <= CHECK;
`else
            out   <= prod;
            done  <= 1'b1;
            ready <= 1'b1;
            state <= IDLE;
`endif
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
`ifdef GF_INV_VERIFY_EN
        CHECK: begin
          check_fail <= (a != '0) && (prod != M'(1));
          out        <= acc;
          done       <= 1'b1;
          ready      <= 1'b1;
          state      <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
